// File: rtl/vector_fp_compare_classify_unit.sv
// Multi-lane IEEE 754 classify / compare / min-max unit with a two-stage valid-ready pipeline.
// S1 holds unpacked class information and magnitude compares; S2 holds lane results, tag and beat NV.
module vector_fp_compare_classify_unit #(
  parameter int LANES = 4,
  parameter int ELEN  = 64,
  parameter int TAG_W = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [3:0]              op_i,
  input  logic                    sew_i,
  input  logic [LANES*ELEN-1:0]   vs2_i,
  input  logic [LANES*ELEN-1:0]   vs1_i,
  input  logic [LANES-1:0]        mask_i,
  input  logic [TAG_W-1:0]        tag_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*ELEN-1:0]   result_o,
  output logic [TAG_W-1:0]        tag_o,
  output logic                    nv_o,
  input  logic                    nv_clear_i,
  output logic                    busy_o
);

  typedef enum logic [3:0] {
    OP_CLASS = 4'd0, OP_EQ = 4'd1, OP_NE = 4'd2, OP_LT = 4'd3, OP_LE = 4'd4,
    OP_GT = 4'd5, OP_GE = 4'd6, OP_MIN = 4'd7, OP_MAX = 4'd8
  } op_e;

  typedef struct packed {
    logic sign;
    logic exp_zero;
    logic exp_ones;
    logic man_zero;
    logic man_msb;
  } fp_fields_t;

  function automatic fp_fields_t fp_unpack(input logic [ELEN-1:0] x, input logic sew);
    fp_fields_t f;
    if (sew) begin
      f.sign     = x[63];
      f.exp_zero = (x[62:52] == 11'd0);
      f.exp_ones = &x[62:52];
      f.man_zero = (x[51:0] == 52'd0);
      f.man_msb  = x[51];
    end else begin
      f.sign     = x[31];
      f.exp_zero = (x[30:23] == 8'd0);
      f.exp_ones = &x[30:23];
      f.man_zero = (x[22:0] == 23'd0);
      f.man_msb  = x[22];
    end
    return f;
  endfunction

  function automatic logic [9:0] fp_classify(input fp_fields_t f);
    logic [9:0] c;
    c = '0;
    if (f.exp_ones && !f.man_zero) c[f.man_msb ? 9 : 8] = 1'b1;
    else if (f.exp_ones)           c[f.sign ? 0 : 7] = 1'b1;
    else if (f.exp_zero && f.man_zero) c[f.sign ? 3 : 4] = 1'b1;
    else if (f.exp_zero)           c[f.sign ? 2 : 5] = 1'b1;
    else                           c[f.sign ? 1 : 6] = 1'b1;
    return c;
  endfunction

  // Magnitude with the sign stripped; binary32 occupies the low 31 bits.
  function automatic logic [ELEN-1:0] fp_magnitude(input logic [ELEN-1:0] x, input logic sew);
    return sew ? {1'b0, x[ELEN-2:0]} : {{(ELEN-31){1'b0}}, x[30:0]};
  endfunction

  logic s1_ready, s2_ready, s1_load, s2_load, out_fire;
  logic vld_p1, vld_p2;

  assign s2_ready    = !vld_p2 | out_ready_i;
  assign s1_ready    = !vld_p1 | s2_ready;
  assign in_ready_o  = s1_ready;
  assign s1_load     = in_valid_i & s1_ready;
  assign s2_load     = vld_p1 & s2_ready;
  assign out_fire    = vld_p2 & out_ready_i;
  assign out_valid_o = vld_p2;
  assign busy_o      = vld_p1 | vld_p2;

  logic [LANES-1:0][9:0] cls_a_d;
  logic [LANES-1:0]      sign_a_d, sign_b_d, nan_b_d, snan_b_d, zero_b_d, lt_d, eq_d;

  always_comb begin
    fp_fields_t fa, fb;
    logic [ELEN-1:0] ma, mb;
    for (int l = 0; l < LANES; l++) begin
      fa = fp_unpack(vs2_i[l*ELEN +: ELEN], sew_i);
      fb = fp_unpack(vs1_i[l*ELEN +: ELEN], sew_i);
      ma = fp_magnitude(vs2_i[l*ELEN +: ELEN], sew_i);
      mb = fp_magnitude(vs1_i[l*ELEN +: ELEN], sew_i);
      cls_a_d[l]  = fp_classify(fa);
      sign_a_d[l] = fa.sign;
      sign_b_d[l] = fb.sign;
      nan_b_d[l]  = fb.exp_ones & !fb.man_zero;
      snan_b_d[l] = fb.exp_ones & !fb.man_zero & !fb.man_msb;
      zero_b_d[l] = fb.exp_zero & fb.man_zero;
      lt_d[l]     = ma < mb;
      eq_d[l]     = ma == mb;
    end
  end

  // ---- S1: unpacked classes, magnitude compares, decoded op ----
  logic [LANES-1:0][9:0]  cls_a_p1;
  logic [LANES-1:0]       sign_a_p1, sign_b_p1, nan_b_p1, snan_b_p1, zero_b_p1, lt_p1, eq_p1;
  logic [LANES-1:0]       mask_p1;
  logic [LANES*ELEN-1:0]  a_p1, b_p1;
  op_e                    op_p1;
  logic                   rsvd_p1, sew_p1;
  logic [TAG_W-1:0]       tag_p1;

  always_ff @(posedge clock) begin
    if (s1_load) begin
      cls_a_p1  <= cls_a_d;
      sign_a_p1 <= sign_a_d;
      sign_b_p1 <= sign_b_d;
      nan_b_p1  <= nan_b_d;
      snan_b_p1 <= snan_b_d;
      zero_b_p1 <= zero_b_d;
      lt_p1     <= lt_d;
      eq_p1     <= eq_d;
      mask_p1   <= mask_i;
      a_p1      <= vs2_i;
      b_p1      <= vs1_i;
      op_p1     <= op_e'(op_i);
      rsvd_p1   <= (op_i > 4'd8);
      sew_p1    <= sew_i;
      tag_p1    <= tag_i;
    end
  end

  logic [LANES*ELEN-1:0] res_d;
  logic [LANES-1:0]      lane_nv;

  always_comb begin
    logic [ELEN-1:0] a, b, mm, lane;
    logic [9:0] ca;
    logic a_nan, a_snan, any_nan, any_snan, both_zero, eq, gt_mag, tot_lt, tot_gt, nv;
    res_d   = '0;
    lane_nv = '0;
    for (int l = 0; l < LANES; l++) begin
      a         = a_p1[l*ELEN +: ELEN];
      b         = b_p1[l*ELEN +: ELEN];
      ca        = cls_a_p1[l];
      a_nan     = ca[8] | ca[9];
      a_snan    = ca[8];
      any_nan   = a_nan | nan_b_p1[l];
      any_snan  = a_snan | snan_b_p1[l];
      both_zero = (ca[3] | ca[4]) & zero_b_p1[l];
      eq        = both_zero | ((sign_a_p1[l] == sign_b_p1[l]) & eq_p1[l]);
      gt_mag    = !lt_p1[l] & !eq_p1[l];
      // Total order with -0 below +0; compares mask out the zero pair separately.
      tot_lt    = (sign_a_p1[l] != sign_b_p1[l]) ? sign_a_p1[l] : (sign_a_p1[l] ? gt_mag : lt_p1[l]);
      tot_gt    = (sign_a_p1[l] != sign_b_p1[l]) ? sign_b_p1[l] : (sign_a_p1[l] ? lt_p1[l] : gt_mag);
      if (a_nan && nan_b_p1[l])
        mm = sew_p1 ? {1'b0, {11{1'b1}}, 1'b1, {(ELEN-13){1'b0}}} : {{(ELEN-32){1'b0}}, 32'h7FC0_0000};
      else if (a_nan)
        mm = b;
      else if (nan_b_p1[l])
        mm = a;
      else if (op_p1 == OP_MIN)
        mm = tot_lt ? a : b;
      else
        mm = tot_lt ? b : a;
      lane = '0;
      nv   = 1'b0;
      case (op_p1)
        OP_CLASS: lane = {{(ELEN-10){1'b0}}, ca};
        OP_EQ: begin lane[0] = !any_nan & eq;                         nv = any_snan; end
        OP_NE: begin lane[0] = any_nan | !eq;                         nv = any_snan; end
        OP_LT: begin lane[0] = !any_nan & tot_lt & !both_zero;        nv = any_nan;  end
        OP_LE: begin lane[0] = !any_nan & ((tot_lt & !both_zero) | eq); nv = any_nan; end
        OP_GT: begin lane[0] = !any_nan & tot_gt & !both_zero;        nv = any_nan;  end
        OP_GE: begin lane[0] = !any_nan & ((tot_gt & !both_zero) | eq); nv = any_nan; end
        OP_MIN, OP_MAX: begin
          lane = sew_p1 ? mm : {{(ELEN-32){1'b1}}, mm[31:0]};
          nv   = any_snan;
        end
        default: begin lane = '0; nv = 1'b0; end
      endcase
      if (mask_p1[l]) begin
        res_d[l*ELEN +: ELEN] = lane;
        lane_nv[l]            = nv;
      end
    end
  end

  // ---- S2: lane results, tag, beat NV; sticky flag ----
  logic nv_p2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      result_o <= '0;
      tag_o    <= '0;
      nv_p2    <= 1'b0;
      nv_o     <= 1'b0;
    end else begin
      vld_p1 <= s1_load | (vld_p1 & !s2_ready);
      vld_p2 <= s2_load | (vld_p2 & !out_ready_i);
      if (s2_load) begin
        result_o <= res_d;
        tag_o    <= tag_p1;
        nv_p2    <= (|lane_nv) | rsvd_p1;
      end
      nv_o <= (nv_o & !nv_clear_i) | (out_fire & nv_p2);
    end
  end

endmodule
